instruction_fetch_unit: RTL and testbench

//  Initiator side of the instruction-memory port: owns the fetch PC and drives addr/en into the

---
 rtl/rvcpu_pkg.sv | 25 ++
 rtl/instruction_fetch_unit_fetch_pc_gen.sv | 57 +++++
 rtl/instruction_fetch_unit.sv | 90 +++++++++
 tb/tb_instruction_fetch_unit.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvcpu_pkg.sv
// Shared CPU constants for the fetch slice: datapath width, instruction size,
// the bubble word, the default reset PC and the PC-generator result bundle.
package rvcpu_pkg;

  localparam int XLEN       = 32;
  localparam int INSN_BYTES = 4;

  localparam logic [XLEN-1:0] NOP_WORD         = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP          = XLEN'(INSN_BYTES);

  // Everything the fetch unit needs from the next-PC mux in one cycle.
  typedef struct packed {
    logic            issue;
    logic [XLEN-1:0] issue_pc;
    logic [XLEN-1:0] fetch_pc_next;
    logic            fault_set;
    logic            fault_clr;
  } pc_gen_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ~(PC_STEP - 1'b1);
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_fetch_pc_gen.sv
// Next-PC mux for the fetch unit: reset > redirect > stall/halt > sequential +4.
// With FETCH_MISALIGN_CHECK_EN defined, misaligned redirects are refused instead of masked.
module fetch_pc_gen
  import rvcpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            rst,
  input  logic [XLEN-1:0] fetch_pc_i,
  input  logic            fault_i,
  input  logic            stall_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_target_i,
  output logic            issue_o,
  output logic [XLEN-1:0] issue_pc_o,
  output logic [XLEN-1:0] fetch_pc_next_o,
  output logic            fault_set_o,
  output logic            fault_clr_o
);

  logic [XLEN-1:0] target;
  logic            target_bad;

  always_comb begin
`ifdef FETCH_MISALIGN_CHECK_EN
    target     = redirect_target_i;
    target_bad = (redirect_target_i & (PC_STEP - 1'b1)) != '0;
`else
    target     = align_pc(redirect_target_i);
    target_bad = 1'b0;
`endif
    issue_o         = 1'b0;
    issue_pc_o      = fetch_pc_i;
    fetch_pc_next_o = fetch_pc_i;
    fault_set_o     = 1'b0;
    fault_clr_o     = 1'b0;

    if (rst) begin
      fetch_pc_next_o = RESET_PC;
      fault_clr_o     = 1'b1;
    end else if (redirect_valid_i) begin
      // Target goes straight to the ROM address this cycle; no extra bubble.
      issue_pc_o = target;
      if (target_bad) begin
        fault_set_o = 1'b1;
      end else begin
        issue_o         = 1'b1;
        fetch_pc_next_o = target + PC_STEP;
        fault_clr_o     = 1'b1;
      end
    end else if (!stall_i && !fault_i) begin
      issue_o         = 1'b1;
      fetch_pc_next_o = fetch_pc_i + PC_STEP;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Front of the pipeline: drives the synchronous instruction ROM and hands fetched
// words to decode. Optional misaligned-redirect trap via FETCH_MISALIGN_CHECK_EN.
module instruction_fetch_unit
  import rvcpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSN = NOP_WORD
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic        imem_en,
  input  logic [31:0] imem_dout,
  input  logic        stall_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_target_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_valid_o,
  output logic        fetch_fault_o
);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  logic            pend_valid_q, pend_valid_d;
  logic            fault_q, fault_d;
  pc_gen_t         gen;

  fetch_pc_gen #(
    .RESET_PC(RESET_PC)
  ) u_pc_gen (
    .rst              (rst),
    .fetch_pc_i       (fetch_pc_q),
    .fault_i          (fault_q),
    .stall_i          (stall_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_target_i(redirect_target_i),
    .issue_o          (gen.issue),
    .issue_pc_o       (gen.issue_pc),
    .fetch_pc_next_o  (gen.fetch_pc_next),
    .fault_set_o      (gen.fault_set),
    .fault_clr_o      (gen.fault_clr)
  );

  // The pending slot mirrors whatever the ROM will present on dout next cycle;
  // while no read is issued the ROM holds dout, so the slot holds too.
  always_comb begin
    fetch_pc_d   = gen.fetch_pc_next;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
    fault_d      = fault_q;
    if (rst) begin
      pend_valid_d = 1'b0;
      pend_pc_d    = RESET_PC;
    end else if (gen.issue) begin
      pend_valid_d = 1'b1;
      pend_pc_d    = gen.issue_pc;
    end else if (gen.fault_set) begin
      pend_valid_d = 1'b0;
    end
    if (gen.fault_clr) begin
      fault_d = 1'b0;
    end else if (gen.fault_set) begin
      fault_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    fetch_pc_q   <= fetch_pc_d;
    pend_pc_q    <= pend_pc_d;
    pend_valid_q <= pend_valid_d;
    fault_q      <= fault_d;
  end

  // Decode handshake: inst_valid_o offers inst_o/inst_pc_o; decode accepts on any
  // cycle with stall_i low. Under stall the offer stays stable until accepted, and
  // a same-cycle redirect withdraws it (the slot is the killed younger instruction).
  assign imem_en      = gen.issue;
  assign imem_addr    = gen.issue_pc;
  assign inst_valid_o = pend_valid_q & ~redirect_valid_i & ~rst;
  assign inst_o       = (pend_valid_q & ~rst) ? imem_dout : NOP_INSN;
  assign inst_pc_o    = pend_pc_q;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign fetch_fault_o = fault_q;
`else
  assign fetch_fault_o = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit with a 1-cycle-latency ROM model, a per-cycle
// reference model of the fetch stream and directed literal checkpoints.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_dout = 32'h0;
  logic        stall_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_target_i;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_valid_o;
  logic        fetch_fault_o;

  int tests = 0;
  int fails = 0;

`ifdef FETCH_MISALIGN_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif
  localparam logic [31:0] NOP = 32'h0000_0013;

  instruction_fetch_unit dut (
    .clk              (clk),
    .rst              (rst),
    .imem_addr        (imem_addr),
    .imem_en          (imem_en),
    .imem_dout        (imem_dout),
    .stall_i          (stall_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_target_i(redirect_target_i),
    .inst_o           (inst_o),
    .inst_pc_o        (inst_pc_o),
    .inst_valid_o     (inst_valid_o),
    .fetch_fault_o    (fetch_fault_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- ROM model ----------------
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    case (a)
      32'd0:   return 32'h0021_0663;
      32'd4:   return 32'h00c0_00ef;
      32'd8:   return 32'h0080_00ef;
      32'd12:  return 32'h0500_0413;
      32'd16:  return 32'h0010_0093;
      default: return {16'hc0de, a[15:0]};
    endcase
  endfunction

  always @(posedge clk) begin
    if (imem_en) imem_dout <= rom_word(imem_addr);
  end

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The model tracks "which instruction decode is looking at" and "which address
  // comes next", updated from the inputs seen at each clock edge.
  logic [31:0] m_next;
  logic [31:0] m_pc;
  bit          m_valid;
  bit          m_fault;
  bit          m_live = 1'b0;

  function automatic bit bad_target(input logic [31:0] t);
    return CHECK_EN && (t % 4 != 0);
  endfunction

  function automatic logic [31:0] used_target(input logic [31:0] t);
    return t - (t % 4);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_next  = 32'h0;
      m_pc    = 32'h0;
      m_valid = 1'b0;
      m_fault = 1'b0;
      m_live  = 1'b1;
    end else if (m_live) begin
      if (redirect_valid_i) begin
        if (bad_target(redirect_target_i)) begin
          m_fault = 1'b1;
          m_valid = 1'b0;
        end else begin
          m_pc    = used_target(redirect_target_i);
          m_next  = m_pc + 32'd4;
          m_valid = 1'b1;
          m_fault = 1'b0;
        end
      end else if (!stall_i && !m_fault) begin
        m_pc    = m_next;
        m_next  = m_next + 32'd4;
        m_valid = 1'b1;
      end
    end
  end

  // ---------------- scoreboard compare, every cycle ----------------
  always @(negedge clk) begin
    if (m_live) begin
      bit          held;
      bit          e_en;
      logic [31:0] e_addr;
      held   = !rst && m_valid;
      e_en   = 1'b0;
      e_addr = m_next;
      if (!rst) begin
        if (redirect_valid_i) begin
          e_en   = !bad_target(redirect_target_i);
          e_addr = used_target(redirect_target_i);
        end else begin
          e_en = !stall_i && !m_fault;
        end
      end
      chk("m_en", 32'(imem_en), 32'(e_en));
      if (e_en) chk("m_addr", imem_addr, e_addr);
      chk("m_valid", 32'(inst_valid_o), 32'(held && !redirect_valid_i));
      chk("m_inst", inst_o, held ? rom_word(m_pc) : NOP);
      if (held) chk("m_pc", inst_pc_o, m_pc);
      chk("m_fault", 32'(fetch_fault_o), 32'(m_fault));
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic drive(input logic s, input logic r, input logic [31:0] t);
    stall_i           = s;
    redirect_valid_i  = r;
    redirect_target_i = t;
  endtask

  initial begin
    logic [15:0] stall_pat;
    stall_pat = 16'b1011_0010_0110_1001;
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0);

    // reset state
    tick(); settle();
    chk("rst_valid", 32'(inst_valid_o), 32'h0);
    chk("rst_en", 32'(imem_en), 32'h0);
    chk("rst_inst", inst_o, NOP);
    chk("rst_fault", 32'(fetch_fault_o), 32'h0);

    // release, sequential stream
    tick(); rst = 1'b0; settle();
    chk("rel_addr0", imem_addr, 32'd0);
    chk("rel_en0", 32'(imem_en), 32'h1);
    chk("rel_valid0", 32'(inst_valid_o), 32'h0);
    tick(); settle();
    chk("seq_addr4", imem_addr, 32'd4);
    chk("seq_pc0", inst_pc_o, 32'd0);
    chk("seq_inst0", inst_o, 32'h0021_0663);
    chk("seq_valid0", 32'(inst_valid_o), 32'h1);
    tick(); settle();
    chk("seq_addr8", imem_addr, 32'd8);
    chk("seq_pc4", inst_pc_o, 32'd4);
    chk("seq_inst4", inst_o, 32'h00c0_00ef);
    tick(); settle();
    chk("seq_addr12", imem_addr, 32'd12);
    chk("seq_pc8", inst_pc_o, 32'd8);
    chk("seq_inst8", inst_o, 32'h0080_00ef);
    tick(); settle();
    chk("seq_addr16", imem_addr, 32'd16);

    // reset mid-run
    tick(); rst = 1'b1; settle();
    chk("mrst_valid", 32'(inst_valid_o), 32'h0);
    chk("mrst_en", 32'(imem_en), 32'h0);
    tick(); rst = 1'b0; settle();
    chk("mrst_valid_after", 32'(inst_valid_o), 32'h0);
    chk("mrst_refetch", imem_addr, 32'd0);
    tick(); settle();
    chk("mrst_pc0", inst_pc_o, 32'd0);

    // stall three cycles holding pc 4
    for (int i = 0; i < 3; i++) begin
      tick(); drive(1'b1, 1'b0, 32'h0); settle();
      chk("stall_en", 32'(imem_en), 32'h0);
      chk("stall_pc", inst_pc_o, 32'd4);
      chk("stall_inst", inst_o, 32'h00c0_00ef);
      chk("stall_valid", 32'(inst_valid_o), 32'h1);
    end
    tick(); drive(1'b0, 1'b0, 32'h0); settle();
    chk("unstall_addr", imem_addr, 32'd8);
    tick(); settle();
    chk("unstall_pc8", inst_pc_o, 32'd8);

    // redirect to 4, then redirect to 12 while pc 4 is presented
    tick(); drive(1'b0, 1'b1, 32'd4); settle();
    chk("redir4_addr", imem_addr, 32'd4);
    tick(); drive(1'b0, 1'b1, 32'd12); settle();
    chk("redir12_kill", 32'(inst_valid_o), 32'h0);
    chk("redir12_addr", imem_addr, 32'd12);
    chk("redir12_en", 32'(imem_en), 32'h1);
    tick(); drive(1'b0, 1'b0, 32'h0); settle();
    chk("redir12_pc", inst_pc_o, 32'd12);
    chk("redir12_inst", inst_o, 32'h0500_0413);
    chk("redir12_valid", 32'(inst_valid_o), 32'h1);
    tick(); settle();
    chk("redir12_then16", inst_pc_o, 32'd16);

    // redirect and stall together
    tick(); drive(1'b1, 1'b1, 32'd16); settle();
    chk("rs_en", 32'(imem_en), 32'h1);
    chk("rs_addr", imem_addr, 32'd16);
    tick(); drive(1'b0, 1'b0, 32'h0); settle();
    chk("rs_pc16", inst_pc_o, 32'd16);
    chk("rs_valid", 32'(inst_valid_o), 32'h1);

    // back-to-back redirects, later wins
    tick(); drive(1'b0, 1'b1, 32'd40);
    tick(); drive(1'b0, 1'b1, 32'd80); settle();
    chk("b2b_kill", 32'(inst_valid_o), 32'h0);
    tick(); drive(1'b0, 1'b0, 32'h0); settle();
    chk("b2b_pc80", inst_pc_o, 32'd80);
    chk("b2b_inst80", inst_o, 32'hc0de_0050);

    // PC wrap at the top of the address space
    tick(); drive(1'b0, 1'b1, 32'hFFFF_FFFC);
    tick(); drive(1'b0, 1'b0, 32'h0); settle();
    chk("wrap_pc", inst_pc_o, 32'hFFFF_FFFC);
    chk("wrap_addr", imem_addr, 32'd0);
    tick(); settle();
    chk("wrap_pc0", inst_pc_o, 32'd0);
    chk("wrap_inst0", inst_o, 32'h0021_0663);

    // misaligned redirect to 14, then aligned redirect to 12
    tick(); drive(1'b0, 1'b1, 32'd14); settle();
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("mis_en", 32'(imem_en), 32'h0);
`else
    chk("mis_addr", imem_addr, 32'd12);
`endif
    tick(); drive(1'b0, 1'b0, 32'h0); settle();
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("mis_fault", 32'(fetch_fault_o), 32'h1);
    chk("mis_halt_en", 32'(imem_en), 32'h0);
    chk("mis_valid", 32'(inst_valid_o), 32'h0);
`else
    chk("mis_pc12", inst_pc_o, 32'd12);
    chk("mis_nofault", 32'(fetch_fault_o), 32'h0);
`endif
    tick(); settle();
    tick(); drive(1'b0, 1'b1, 32'd12); settle();
    chk("fix_addr", imem_addr, 32'd12);
    chk("fix_en", 32'(imem_en), 32'h1);
    tick(); drive(1'b0, 1'b0, 32'h0); settle();
    chk("fix_pc12", inst_pc_o, 32'd12);
    chk("fix_fault", 32'(fetch_fault_o), 32'h0);

    // stall pattern, model-checked every cycle
    for (int i = 0; i < 16; i++) begin
      tick(); drive(stall_pat[i], 1'b0, 32'h0);
    end

    // reset while stalling and redirecting
    tick(); rst = 1'b1; drive(1'b1, 1'b1, 32'd40); settle();
    chk("rsr_en", 32'(imem_en), 32'h0);
    chk("rsr_valid", 32'(inst_valid_o), 32'h0);
    tick(); rst = 1'b0; drive(1'b0, 1'b0, 32'h0); settle();
    chk("rsr_addr0", imem_addr, 32'd0);
    chk("rsr_valid_after", 32'(inst_valid_o), 32'h0);
    tick(); settle();
    chk("rsr_pc0", inst_pc_o, 32'd0);
    chk("rsr_inst0", inst_o, 32'h0021_0663);

    tick(); settle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
